// File: rtl/zero_cross_mul_arbiter.sv
// Round-robin share of one 2-stage signed x unsigned multiplier; result 1 cycle after grant.
// A result held by res_ready=0 freezes the multiplier (mul_ce=0) and blocks all grants.
module zero_cross_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*34-1:0]   req_b,
  output logic                 mul_ce,
  output logic [31:0]          mul_din0,
  output logic [33:0]          mul_din1,
  input  logic [64:0]          mul_dout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [64:0]          res_data,
  output logic [31:0]          ops_count
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            tag_vld_q, tag_vld_d;
  logic [ID_W-1:0] tag_id_q, tag_id_d;
  logic [31:0]     ops_cnt_q, ops_cnt_d;

  logic            stall;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;

  assign stall     = tag_vld_q & ~res_ready;
  assign mul_ce    = ~stall;
  assign res_valid = tag_vld_q;
  assign res_id    = tag_id_q;
  assign res_data  = mul_dout;
  assign ops_count = ops_cnt_q;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = rr_ptr_q;
    if (reset && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
        cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && grant_idx == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[i*32 +: 32];
        mul_din1     = req_b[i*34 +: 34];
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    ops_cnt_d = ops_cnt_q;
    if (!stall) begin
      if (grant_vld) begin
        rr_ptr_d  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        tag_vld_d = 1'b1;
        tag_id_d  = grant_idx;
        ops_cnt_d = (ops_cnt_q == 32'hFFFF_FFFF) ? ops_cnt_q : ops_cnt_q + 32'd1;
      end else begin
        tag_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= '0;
      ops_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end

endmodule

// File: tb/tb_zero_cross_mul_arbiter.sv
// Directed bench for zero_cross_mul_arbiter with a behavioural ce-gated multiplier register.
module tb_zero_cross_mul_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_a;
  logic [135:0]  req_b;
  logic          mul_ce;
  logic [31:0]   mul_din0;
  logic [33:0]   mul_din1;
  logic [64:0]   mul_dout;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_id;
  logic [64:0]   res_data;
  logic [31:0]   ops_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zero_cross_mul_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .ops_count(ops_count)
  );

  // Shared multiplier: one register stage, no reset, frozen while ce is low.
  logic signed [64:0] prod;
  assign prod = $signed(mul_din0) * $signed({1'b0, mul_din1});
  always @(posedge clk) if (mul_ce) mul_dout <= prod;

  typedef struct {
    logic         rst_n;
    logic [3:0]   vld;
    logic [127:0] a;
    logic [135:0] b;
    logic         rr;
    logic [3:0]   e_rdy;
    logic         e_ce;
    logic         e_rv;
    logic [1:0]   e_id;
    logic [64:0]  e_data;
    logic [31:0]  e_cnt;
  } row_t;

  function automatic logic [127:0] pa(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [135:0] pb(input logic [33:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic row_t mk(input logic rst_n, input logic [3:0] vld, input logic [127:0] a,
                              input logic [135:0] b, input logic rr, input logic [3:0] e_rdy,
                              input logic e_ce, input logic e_rv, input logic [1:0] e_id,
                              input logic [64:0] e_data, input logic [31:0] e_cnt);
    row_t r;
    r.rst_n = rst_n; r.vld = vld; r.a = a; r.b = b; r.rr = rr;
    r.e_rdy = e_rdy; r.e_ce = e_ce; r.e_rv = e_rv; r.e_id = e_id;
    r.e_data = e_data; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Inputs change just after the edge; outputs are sampled 1 time unit later.
  task automatic apply(input row_t r, input string nm);
    @(posedge clk);
    #1;
    reset     = r.rst_n;
    req_valid = r.vld;
    req_a     = r.a;
    req_b     = r.b;
    res_ready = r.rr;
    #1;
    chk({nm, ".req_ready"}, 128'(req_ready), 128'(r.e_rdy));
    chk({nm, ".mul_ce"},    128'(mul_ce),    128'(r.e_ce));
    chk({nm, ".res_valid"}, 128'(res_valid), 128'(r.e_rv));
    chk({nm, ".ops_count"}, 128'(ops_count), 128'(r.e_cnt));
    if (r.e_rv) begin
      chk({nm, ".res_id"},   128'(res_id),   128'(r.e_id));
      chk({nm, ".res_data"}, 128'(res_data), 128'(r.e_data));
    end
  endtask

  row_t tbl [13];
  logic [127:0] fa;
  logic [135:0] fb;

  initial begin
    fa = pa(32'd1, 32'd2, 32'd3, 32'd4);
    fb = pb(34'd10, 34'd20, 34'd30, 34'd40);
    //               rst  vld      a                               b                                            rr  rdy      ce   rv   id     data                       cnt
    tbl[0]  = mk(1'b1, 4'b0001, pa(32'd3, 0, 0, 0),            pb(34'd5, 0, 0, 0),                        1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 65'd0,                     32'd0);
    tbl[1]  = mk(1'b1, 4'b0000, fa,                            fb,                                        1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 65'd15,                    32'd1);
    tbl[2]  = mk(1'b1, 4'b0001, pa(32'hFFFF_FFFF, 0, 0, 0),    pb(34'h3_FFFF_FFFF, 0, 0, 0),              1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 65'd0,                     32'd1);
    tbl[3]  = mk(1'b1, 4'b1111, fa,                            fb,                                        1'b1, 4'b0010, 1'b1, 1'b1, 2'd0, 65'h1_FFFF_FFFC_0000_0001, 32'd2);
    tbl[4]  = mk(1'b1, 4'b1111, fa,                            fb,                                        1'b1, 4'b0100, 1'b1, 1'b1, 2'd1, 65'd40,                    32'd3);
    tbl[5]  = mk(1'b1, 4'b1111, fa,                            fb,                                        1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 65'd90,                    32'd4);
    tbl[6]  = mk(1'b1, 4'b1111, fa,                            fb,                                        1'b1, 4'b0001, 1'b1, 1'b1, 2'd3, 65'd160,                   32'd5);
    tbl[7]  = mk(1'b1, 4'b1111, fa,                            fb,                                        1'b1, 4'b0010, 1'b1, 1'b1, 2'd0, 65'd10,                    32'd6);
    tbl[8]  = mk(1'b1, 4'b0000, fa,                            fb,                                        1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 65'd40,                    32'd7);
    tbl[9]  = mk(1'b1, 4'b0001, pa(32'd7, 0, 0, 0),            pb(34'd6, 0, 0, 0),                        1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 65'd0,                     32'd7);
    tbl[10] = mk(1'b1, 4'b0000, fa,                            fb,                                        1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 65'd42,                    32'd8);
    tbl[11] = mk(1'b1, 4'b1011, pa(32'd1, 32'd5, 0, 32'd9),    pb(34'd1, 34'd9, 0, 34'd9),                1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 65'd0,                     32'd8);
    tbl[12] = mk(1'b1, 4'b0000, fa,                            fb,                                        1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 65'd45,                    32'd9);

    reset     = 1'b0;
    req_valid = 4'b1111;
    req_a     = fa;
    req_b     = fb;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 128'(req_ready), 128'(4'b0000));
    chk("rst.res_valid", 128'(res_valid), 128'(1'b0));
    chk("rst.res_id",    128'(res_id),    128'(2'd0));
    chk("rst.ops_count", 128'(ops_count), 128'(32'd0));

    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: requester 2 result held 3 cycles while requester 1 waits.
    apply(mk(1'b1, 4'b0100, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 65'd0,  32'd9),  "bp0");
    apply(mk(1'b1, 4'b0010, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 65'd42, 32'd10), "bp1");
    apply(mk(1'b1, 4'b0010, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 65'd42, 32'd10), "bp2");
    apply(mk(1'b1, 4'b0010, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 65'd42, 32'd10), "bp3");
    apply(mk(1'b1, 4'b0010, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b1, 4'b0010, 1'b1, 1'b1, 2'd2, 65'd42, 32'd10), "bp4");
    apply(mk(1'b1, 4'b0000, pa(0, 32'd11, 32'd6, 0), pb(0, 34'd2, 34'd7, 0), 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 65'd22, 32'd11), "bp5");

    // Reset while a result is stalled: result discarded, pointer back to 0.
    apply(mk(1'b1, 4'b0001, pa(32'd2, 0, 0, 0),       pb(34'd2, 0, 0, 0),       1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 65'd0,  32'd11), "rs0");
    apply(mk(1'b0, 4'b0000, pa(32'd2, 0, 0, 0),       pb(34'd2, 0, 0, 0),       1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 65'd4,  32'd12), "rs1");
    apply(mk(1'b1, 4'b1001, pa(32'd9, 0, 0, 32'd8),   pb(34'd3, 0, 0, 34'd5),   1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 65'd0,  32'd0),  "rs2");
    apply(mk(1'b1, 4'b0000, pa(32'd9, 0, 0, 32'd8),   pb(34'd3, 0, 0, 34'd5),   1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 65'd27, 32'd1),  "rs3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zero_cross_mul_arbiter.md
# zero_cross_mul_arbiter

Round-robin arbiter sharing one 2-stage signed×unsigned multiplier (32-bit signed × 34-bit unsigned → 65-bit, one register stage gated by `ce`) among `NREQ` requesters in the zero_cross datapath. Each requester presents operands with a valid/ready handshake. The arbiter issues at most one operation per cycle, drives the multiplier's `ce`/operands, and tags each operation with its requester id. It returns the 65-bit product on a shared result channel with backpressure, stalling the multiplier pipeline through `ce` when the result is not accepted.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `ID_W`, 2: width of requester id; must satisfy 2^ID_W ≥ NREQ.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid`  in  NREQ  per-requester operation request.
- `req_ready`  out  NREQ  per-requester grant; handshake completes when valid & ready.
- `req_a`  in  NREQ*32  signed multiplicands, requester i at bits [32i+31:32i].
- `req_b`  in  NREQ*34  unsigned multipliers, requester i at bits [34i+33:34i].
- `mul_ce`  out  1  clock enable to the shared multiplier.
- `mul_din0`  out  32  operand A to the multiplier.
- `mul_din1`  out  34  operand B to the multiplier.
- `mul_dout`  in  65  registered multiplier product.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts result.
- `res_id`  out  ID_W  requester index owning the result.
- `res_data`  out  65  product; equals `mul_dout`.
- `ops_count`  out  32  saturating count of issued operations.

## Operation
- `stall` = `res_valid` & ~`res_ready`. `mul_ce` = ~`stall` (combinational).
- Arbitration (combinational, only when ~`stall`): scan indices `rr_ptr`, `rr_ptr`+1, … mod NREQ; the first with `req_valid` set is granted. `req_ready` is one-hot for the granted index, otherwise all zero. During `stall`, `req_ready` = 0.
- On grant to i: `mul_din0` = `req_a[i]`, `mul_din1` = `req_b[i]`. With no grant, both are driven 0.
- On grant, at the clock edge:
  - `rr_ptr` ← (i+1) mod NREQ.
  - Tag register ← {valid=1, id=i}.
  - `ops_count` ← `ops_count`+1, saturating at 0xFFFF_FFFF.
- No grant and no stall: tag valid ← 0. During stall, the tag register and `rr_ptr` hold.
- `res_valid` = tag valid, `res_id` = tag id, `res_data` = `mul_dout`. Product is `$signed(a)` × `{1'b0,b}`, truncated to 65 bits by the multiplier; the arbiter does no arithmetic.
- Reset (`reset`=0 at an edge):
  - `rr_ptr`=0, tag valid=0, tag id=0, `ops_count`=0.
  - Thus `res_valid`=0 and `res_id`=0 from the following cycle.
  - An in-flight or stalled result is discarded.
  - The multiplier register has no reset; `res_data` is don't-care while `res_valid`=0.
- During reset cycles, `req_ready` is forced 0 and no `ops_count` increment occurs.

## Timing
- Issue-to-result latency: 1 cycle. A grant in cycle T gives `res_valid`=1 in T+1 with the product.
- Throughput: one operation per cycle while `res_ready`=1.
- A result in T+1 with `res_ready`=0 holds `res_valid`, `res_id` and `res_data` stable, and grants nothing, until the cycle `res_ready`=1. In that cycle a new grant is allowed (back-to-back).
- `req_valid` dropped before a grant: nothing is issued. Requesters must hold operands stable while valid & ~ready.
- Simultaneous requests: exactly one grant per cycle. No requester waits more than NREQ-1 grants.

## Test plan
- Single op: reset, then `req_valid`=0001 with a=3, b=5 → `req_ready`=0001 in T; T+1 `res_valid`=1, `res_id`=0, `res_data`=15; `ops_count`=1.
- Signed extreme: a=0xFFFF_FFFF (−1), b=0x3_FFFF_FFFF → `res_data`=0x1_FFFF_FFFC_0000_0001.
- Fairness: all four requesters hold valid continuously with `res_ready`=1 → grants 0,1,2,3,0,1… one per cycle, with matching `res_id` sequence one cycle later.
- Backpressure: issue op from requester 2, hold `res_ready`=0 for 3 cycles while requester 1 is valid. Required: `mul_ce`=0, `req_ready`=0, and result/id stable throughout. Raising `res_ready` grants requester 1 that cycle; its result appears next cycle.
- Reset mid-stall: `res_valid`=1 stalled, assert `reset`=0 for one cycle. Next cycle `res_valid`=0, `ops_count`=0, `rr_ptr`=0; requesters 0 and 3 both valid → requester 0 granted first.
- Rotation skip: `rr_ptr`=2 with only requester 0 valid → granted 0; `rr_ptr` becomes 1.
